// File: rtl/req_ack_monitor.sv
// rtl/req_ack_monitor.sv - N-channel req/ack latency-window protocol monitor
module req_ack_monitor #(
   parameter int N_CH    = 4,
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 4,
   parameter int CNT_W   = 16,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CH-1:0]     req,
   input  logic [N_CH-1:0]     ack,
   input  logic                clr_err,
   output logic [N_CH-1:0]     err_pulse,
   output logic [3*N_CH-1:0]   err_code,
   output logic [N_CH-1:0]     err_sticky,
   output logic                first_err_valid,
   output logic [CH_W-1:0]     first_err_chan,
   output logic [2:0]          first_err_code,
   output logic [CNT_W-1:0]    pass_cnt
);

   localparam int LAT_W = $clog2(MAX_LAT + 2);
   localparam int PC_W  = $clog2(N_CH + 1);
   localparam int SUM_W = CNT_W + PC_W;

   localparam logic [2:0] E_NONE     = 3'd0;
   localparam logic [2:0] E_EARLY    = 3'd1;
   localparam logic [2:0] E_TIMEOUT  = 3'd2;
   localparam logic [2:0] E_SPURIOUS = 3'd3;
   localparam logic [2:0] E_OVERLAP  = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           st_q  [N_CH];
   state_t           st_n  [N_CH];
   logic [LAT_W-1:0] lat_q [N_CH];
   logic [LAT_W-1:0] lat_n [N_CH];

   logic [N_CH-1:0]   req_q, ack_q, req_rise, ack_rise;
   logic [N_CH-1:0]   err_n, pass_n;
   logic [3*N_CH-1:0] code_n;
   logic [PC_W-1:0]   pop;
   logic [SUM_W-1:0]  sum;
   logic [CH_W-1:0]   fchan_n;
   logic [2:0]        fcode_n;

   assign req_rise = req & ~req_q;
   assign ack_rise = ack & ~ack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         ack_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= S_IDLE;
            lat_q[i] <= '0;
         end
      end else begin
         req_q <= req;
         ack_q <= ack;
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= st_n[i];
            lat_q[i] <= lat_n[i];
         end
      end
   end

   // lat reaching MAX_LAT+1 means the MAX_LAT cycle went by without an ack
   always_comb begin
      code_n = '0;
      err_n  = '0;
      pass_n = '0;
      for (int i = 0; i < N_CH; i++) begin
         st_n[i]  = st_q[i];
         lat_n[i] = lat_q[i];
         case (st_q[i])
            S_IDLE: begin
               if (ack_rise[i]) code_n[3*i +: 3] = E_SPURIOUS;
               if (req_rise[i]) begin
                  st_n[i]  = S_WAIT;
                  lat_n[i] = LAT_W'(1);
               end
            end
            default: begin
               if (lat_q[i] > LAT_W'(MAX_LAT)) begin
                  code_n[3*i +: 3] = E_TIMEOUT;
                  st_n[i]  = req_rise[i] ? S_WAIT : S_IDLE;
                  lat_n[i] = req_rise[i] ? LAT_W'(1) : '0;
               end else if (ack_rise[i]) begin
                  if (lat_q[i] < LAT_W'(MIN_LAT)) code_n[3*i +: 3] = E_EARLY;
                  else                            pass_n[i] = 1'b1;
                  st_n[i]  = req_rise[i] ? S_WAIT : S_IDLE;
                  lat_n[i] = req_rise[i] ? LAT_W'(1) : '0;
               end else if (req_rise[i]) begin
                  code_n[3*i +: 3] = E_OVERLAP;
                  lat_n[i] = LAT_W'(1);
               end else begin
                  lat_n[i] = lat_q[i] + LAT_W'(1);
               end
            end
         endcase
         err_n[i] = (code_n[3*i +: 3] != E_NONE);
      end
   end

   always_comb begin
      pop     = '0;
      fchan_n = '0;
      fcode_n = E_NONE;
      for (int i = 0; i < N_CH; i++) pop = pop + PC_W'(pass_n[i]);
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (err_n[i]) begin
            fchan_n = CH_W'(i);
            fcode_n = code_n[3*i +: 3];
         end
      end
      sum = SUM_W'(pass_cnt) + SUM_W'(pop);
   end

   // an error in the same cycle as clr_err takes precedence over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse       <= '0;
         err_code        <= '0;
         err_sticky      <= '0;
         first_err_valid <= 1'b0;
         first_err_chan  <= '0;
         first_err_code  <= '0;
         pass_cnt        <= '0;
      end else begin
         err_pulse  <= err_n;
         err_code   <= code_n;
         err_sticky <= (clr_err ? '0 : err_sticky) | err_n;
         if (clr_err || !first_err_valid) begin
            if (|err_n) begin
               first_err_valid <= 1'b1;
               first_err_chan  <= fchan_n;
               first_err_code  <= fcode_n;
            end else if (clr_err) begin
               first_err_valid <= 1'b0;
               first_err_chan  <= '0;
               first_err_code  <= '0;
            end
         end
         pass_cnt <= (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_req_ack_monitor.sv
// tb/tb_req_ack_monitor.sv - directed bench for req_ack_monitor (N_CH=4, MIN=2, MAX=3, CNT_W=2)
module tb_req_ack_monitor;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  ack;
   logic        clr_err;
   logic [3:0]  err_pulse;
   logic [11:0] err_code;
   logic [3:0]  err_sticky;
   logic        first_err_valid;
   logic [1:0]  first_err_chan;
   logic [2:0]  first_err_code;
   logic [1:0]  pass_cnt;

   int checks = 0;
   int passed = 0;

   req_ack_monitor #(.N_CH(4), .MIN_LAT(2), .MAX_LAT(3), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clr_err(clr_err),
      .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky),
      .first_err_valid(first_err_valid), .first_err_chan(first_err_chan),
      .first_err_code(first_err_code), .pass_cnt(pass_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_pulse"},  32'(err_pulse), 32'h0);
      chk({tag, "_code"},   32'(err_code), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; ack = '0; clr_err = 1'b0;
      step(); step();
      chk("rst_pulse", 32'(err_pulse), 0);
      chk("rst_sticky", 32'(err_sticky), 0);
      chk("rst_fvalid", 32'(first_err_valid), 0);
      chk("rst_pcnt", 32'(pass_cnt), 0);
      rst_n = 1'b1;
      step();

      // ch0 pass at latency 2
      req = 4'b0001; step();
      chk_idle_outputs("p_req");
      step();
      chk_idle_outputs("p_lat2");
      ack = 4'b0001; step();
      chk("p_pulse", 32'(err_pulse), 0);
      chk("p_cnt", 32'(pass_cnt), 1);
      req = '0; ack = '0; step();

      // ch0 EARLY: ack one cycle after req
      req = 4'b0001; step();
      ack = 4'b0001; step();
      chk("e_pulse", 32'(err_pulse), 32'h1);
      chk("e_code", 32'(err_code), 32'h001);
      chk("e_sticky", 32'(err_sticky), 32'h1);
      chk("e_fvalid", 32'(first_err_valid), 1);
      chk("e_fchan", 32'(first_err_chan), 0);
      chk("e_fcode", 32'(first_err_code), 1);
      step();
      chk_idle_outputs("e_after");
      req = '0; ack = '0; step();

      // ch1 TIMEOUT 4 edges after req, coinciding with clr_err
      req = 4'b0010; step();
      step(); step(); step();
      chk_idle_outputs("t_lat_max");
      clr_err = 1'b1; step();
      clr_err = 1'b0;
      chk("t_pulse", 32'(err_pulse), 32'h2);
      chk("t_code", 32'(err_code), 32'h010);
      chk("t_sticky", 32'(err_sticky), 32'h2);
      chk("t_fvalid", 32'(first_err_valid), 1);
      chk("t_fchan", 32'(first_err_chan), 1);
      chk("t_fcode", 32'(first_err_code), 2);
      step();
      chk_idle_outputs("t_after");
      req = '0; step();

      // ch3 enters WAIT, clear, then SPURIOUS on ch2 with OVERLAP on ch3
      req = 4'b1000; step();
      req = 4'b0000; clr_err = 1'b1; step();
      clr_err = 1'b0;
      chk("c_sticky", 32'(err_sticky), 0);
      chk("c_fvalid", 32'(first_err_valid), 0);
      req = 4'b1000; ack = 4'b0100; step();
      chk("so_pulse", 32'(err_pulse), 32'hC);
      chk("so_code", 32'(err_code), 32'h8C0);
      chk("so_sticky", 32'(err_sticky), 32'hC);
      chk("so_fchan", 32'(first_err_chan), 2);
      chk("so_fcode", 32'(first_err_code), 3);
      step();
      chk_idle_outputs("so_after");
      ack = 4'b1100; step();
      chk("so_pass_pulse", 32'(err_pulse), 0);
      chk("so_pass_cnt", 32'(pass_cnt), 2);
      req = '0; ack = '0; step();

      // four simultaneous passes saturate the 2-bit counter
      req = 4'b1111; step();
      step();
      ack = 4'b1111; step();
      chk("sat_pulse", 32'(err_pulse), 0);
      chk("sat_cnt", 32'(pass_cnt), 3);
      req = '0; ack = '0; step();

      // reset mid-WAIT abandons the transaction silently
      req = 4'b0001; step();
      rst_n = 1'b0; #2;
      chk("mr_sticky", 32'(err_sticky), 0);
      chk("mr_fvalid", 32'(first_err_valid), 0);
      chk("mr_pcnt", 32'(pass_cnt), 0);
      req = '0; step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("mr_quiet", 32'(err_pulse), 0);
      end
      chk("mr_sticky_end", 32'(err_sticky), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
